// File: rtl/sa_feed_skew.sv
// Input feeder for the H-row systolic array: unskewed weight beats in weight mode,
// diagonally skewed activation beats (row r delayed r+1 cycles) in compute mode.
module sa_feed_skew #(
   parameter int H  = 32,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ctrl_in,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [H*DW-1:0] in_data,
   output logic [H*DW-1:0] out_data,
   output logic [H-1:0]  out_valid,
   output logic          out_wshift,
   output logic          wload_done,
   output logic          wload_err
);

   localparam int CW = $clog2(H + 1);

   typedef enum logic [2:0] {IDLE, WLOAD, WHOLD, COMPUTE, DRAIN} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   wcnt, wcnt_nx, dcnt, dcnt_nx;
   logic            w_acc, c_acc, shift_en, done_nx, err_nx;

   logic [H*DW-1:0] sk_p [H-1];
   logic [H-2:0]    vld_p;

   assign in_ready = (state == WLOAD) || (state == COMPUTE);

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      dcnt_nx  = dcnt;
      w_acc    = 1'b0;
      c_acc    = 1'b0;
      shift_en = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      case (state)
         IDLE: state_nx = ctrl_in ? WLOAD : COMPUTE;
         WLOAD: begin
            // a mode change wins over a beat offered in the same cycle
            if (!ctrl_in) begin
               err_nx   = 1'b1;
               wcnt_nx  = '0;
               state_nx = COMPUTE;
            end else if (in_valid) begin
               w_acc = 1'b1;
               if (wcnt == CW'(H - 1)) begin
                  done_nx  = 1'b1;
                  wcnt_nx  = '0;
                  state_nx = WHOLD;
               end else begin
                  wcnt_nx = wcnt + CW'(1);
               end
            end
         end
         WHOLD: if (!ctrl_in) state_nx = COMPUTE;
         COMPUTE: begin
            shift_en = 1'b1;
            if (ctrl_in) begin
               state_nx = DRAIN;
               dcnt_nx  = '0;
            end else begin
               c_acc = in_valid;
            end
         end
         DRAIN: begin
            shift_en = 1'b1;
            if (!ctrl_in) begin
               state_nx = COMPUTE;
            end else if (dcnt == CW'(H - 1)) begin
               state_nx = WLOAD;
               dcnt_nx  = '0;
            end else begin
               dcnt_nx = dcnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // p0: accept into skew line / weight register; p1..: row r leaves after r+1 cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wcnt       <= '0;
         dcnt       <= '0;
         out_wshift <= 1'b0;
         wload_done <= 1'b0;
         wload_err  <= 1'b0;
         out_valid  <= '0;
         vld_p      <= '0;
         out_data   <= '0;
         for (int k = 0; k < H - 1; k++) sk_p[k] <= '0;
      end else begin
         state      <= state_nx;
         wcnt       <= wcnt_nx;
         dcnt       <= dcnt_nx;
         out_wshift <= w_acc;
         wload_done <= done_nx;
         wload_err  <= err_nx;
         if (shift_en) begin
            vld_p[0]     <= c_acc;
            out_valid[0] <= c_acc;
            for (int k = 1; k < H - 1; k++) vld_p[k] <= vld_p[k-1];
            for (int r = 1; r < H; r++) out_valid[r] <= vld_p[r-1];
            if (c_acc) begin
               sk_p[0]          <= in_data;
               out_data[0 +: DW] <= in_data[0 +: DW];
            end
            for (int k = 1; k < H - 1; k++) sk_p[k] <= sk_p[k-1];
            for (int r = 1; r < H; r++) out_data[r*DW +: DW] <= sk_p[r-1][r*DW +: DW];
         end else begin
            vld_p     <= '0;
            out_valid <= '0;
            if (w_acc) out_data <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_sa_feed_skew.sv
// Bench for sa_feed_skew (H=4, DW=8): a table-driven weight-load sequence, directed
// corner sequences and randomized traffic, all checked against a mode/history model.
module tb_sa_feed_skew;

   localparam int H  = 4;
   localparam int DW = 8;
   localparam int M_IDLE = 0, M_WLOAD = 1, M_WHOLD = 2, M_COMP = 3, M_DRAIN = 4;

   logic          clk = 1'b0;
   logic          rst, ctrl_in, in_valid, in_ready;
   logic [H*DW-1:0] in_data, out_data;
   logic [H-1:0]  out_valid;
   logic          out_wshift, wload_done, wload_err;

   sa_feed_skew #(.H(H), .DW(DW)) dut (
      .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
      .out_wshift(out_wshift), .wload_done(wload_done), .wload_err(wload_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: mode, beat counters, and a per-cycle history of compute accepts
   int          ms = M_IDLE, mwc = 0, mdc = 0;
   bit          mknown = 0;
   bit          hv[$];
   logic [31:0] hd[$];
   logic [31:0] wdata;
   logic        rdy_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clear_hist();
      hv.delete();
      hd.delete();
      for (int k = 0; k < H; k++) begin
         hv.push_back(1'b0);
         hd.push_back('0);
      end
   endtask

   task automatic step(input bit r, input bit c, input bit v, input logic [31:0] d);
      bit          ent_v, e_ws, e_done, e_err;
      logic [31:0] ent_d, tmp;
      logic [H-1:0] ev;
      rst = r; ctrl_in = c; in_valid = v; in_data = d;
      #1;
      rdy_s = in_ready;
      if (mknown) chk("in_ready", 32'(rdy_s), 32'(ms == M_WLOAD || ms == M_COMP));
      ent_v = 0; ent_d = '0; e_ws = 0; e_done = 0; e_err = 0;
      if (r) begin
         ms = M_IDLE; mwc = 0; mdc = 0;
         clear_hist();
      end else begin
         case (ms)
            M_IDLE: ms = c ? M_WLOAD : M_COMP;
            M_WLOAD:
               if (!c) begin
                  e_err = 1; mwc = 0; ms = M_COMP;
               end else if (v) begin
                  e_ws = 1; wdata = d; mwc++;
                  if (mwc == H) begin
                     e_done = 1; mwc = 0; ms = M_WHOLD;
                  end
               end
            M_WHOLD: if (!c) ms = M_COMP;
            M_COMP:
               if (c) begin
                  ms = M_DRAIN; mdc = 0;
               end else if (v) begin
                  ent_v = 1; ent_d = d;
               end
            default:
               if (!c) ms = M_COMP;
               else if (mdc == H - 1) begin
                  ms = M_WLOAD; mdc = 0;
               end else mdc++;
         endcase
         hv.push_front(ent_v);
         hd.push_front(ent_d);
         void'(hv.pop_back());
         void'(hd.pop_back());
      end
      @(posedge clk);
      #1;
      if (r) mknown = 1;
      if (mknown) begin
         chk("out_wshift", 32'(out_wshift), 32'(e_ws));
         chk("wload_done", 32'(wload_done), 32'(e_done));
         chk("wload_err", 32'(wload_err), 32'(e_err));
         for (int k = 0; k < H; k++) ev[k] = hv[k];
         chk("out_valid", 32'(out_valid), 32'(ev));
         if (r) chk("out_data_rst", out_data, 32'h0);
         if (e_ws) chk("weight_data", out_data, wdata);
         for (int k = 0; k < H; k++)
            if (hv[k]) begin
               tmp = hd[k];
               chk($sformatf("row%0d_data", k), 32'(out_data[k*DW +: DW]), 32'(tmp[k*DW +: DW]));
            end
      end
   endtask

   typedef struct {
      bit          r, c, v;
      logic [31:0] d;
      bit          rdy, ws, done;
   } vec_t;

   vec_t        tbl[7];
   logic [H-1:0] ov[8];
   logic [7:0]  r3[8];
   logic [7:0]  v3_pat, v0_pat;
   int          zeros, seen;
   logic [H-1:0] acc_v;
   bit          rc;

   initial begin
      // weight-load sequence after reset: rows carry r+1
      tbl[0] = '{1, 1, 0, 32'h0,        0, 0, 0};
      tbl[1] = '{0, 1, 0, 32'h0,        0, 0, 0};
      tbl[2] = '{0, 1, 1, 32'h04030201, 1, 1, 0};
      tbl[3] = '{0, 1, 1, 32'h04030201, 1, 1, 0};
      tbl[4] = '{0, 1, 1, 32'h04030201, 1, 1, 0};
      tbl[5] = '{0, 1, 1, 32'h04030201, 1, 1, 1};
      tbl[6] = '{0, 1, 1, 32'h04030201, 0, 0, 0};

      clear_hist();
      rst = 1; ctrl_in = 1; in_valid = 0; in_data = '0;
      @(posedge clk); #1;
      step(1, 1, 0, '0);
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_rdy", i), 32'(rdy_s), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_ws", i), 32'(out_wshift), 32'(tbl[i].ws));
         chk($sformatf("tbl%0d_done", i), 32'(wload_done), 32'(tbl[i].done));
      end

      // two compute beats: row 3 sees 0x03 then 0x13 on consecutive cycles
      step(0, 0, 0, '0);
      step(0, 0, 1, 32'h03020100); ov[0] = out_valid; r3[0] = out_data[31:24];
      step(0, 0, 1, 32'h13121110); ov[1] = out_valid; r3[1] = out_data[31:24];
      for (int i = 2; i < 6; i++) begin
         step(0, 0, 0, '0); ov[i] = out_valid; r3[i] = out_data[31:24];
      end
      chk("skew_row0_t1", 32'(ov[0][0]), 32'd1);
      chk("skew_row3_early", 32'(ov[2][3]), 32'd0);
      chk("skew_row3_t4", {31'd0, ov[3][3]}, 32'd1);
      chk("skew_row3_A", 32'(r3[3]), 32'h03);
      chk("skew_row3_B", 32'(r3[4]), 32'h13);

      // 2-cycle input gap reproduces as a 2-cycle bubble per row, shifted by r
      for (int i = 0; i < 8; i++) begin
         step(0, 0, (i == 0 || i == 3), $urandom());
         v0_pat[i] = out_valid[0];
         v3_pat[i] = out_valid[3];
      end
      chk("gap_row0", 32'(v0_pat), 32'h09);
      chk("gap_row3", 32'(v3_pat), 32'h48);

      // compute -> weight while a beat is still in flight toward row 3
      step(0, 0, 1, 32'hA3A2A1A0);
      step(0, 1, 1, 32'h0);
      zeros = 0; seen = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 32'h0);
         if (!rdy_s) zeros++;
         if (out_valid[3]) seen++;
      end
      chk("drain_ready_low", zeros, 4);
      chk("drain_row3_emitted", seen, 1);
      chk("drain_valid_clear", 32'(out_valid), 32'h0);
      step(0, 1, 0, '0);
      chk("wload_after_drain", 32'(rdy_s), 32'd1);

      // aborted weight phase: err pulse, no done, compute then accepts
      step(0, 1, 1, 32'h11111111);
      step(0, 1, 1, 32'h22222222);
      step(0, 0, 1, 32'h33333333);
      chk("abort_err", 32'(wload_err), 32'd1);
      chk("abort_no_done", 32'(wload_done), 32'd0);
      step(0, 0, 1, 32'h44444444);
      chk("abort_then_accept", 32'(out_valid[0]), 32'd1);

      // reset with beats in flight
      step(0, 0, 1, $urandom());
      step(0, 0, 1, $urandom());
      step(1, 0, 1, $urandom());
      chk("rst_data_zero", out_data, 32'h0);
      chk("rst_valid_zero", 32'(out_valid), 32'h0);
      acc_v = '0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, '0);
         acc_v |= out_valid;
      end
      chk("rst_no_valids", 32'(acc_v), 32'h0);

      // randomized traffic against the model
      rc = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) rc = ~rc;
         step(($urandom_range(0, 199) == 0), rc, ($urandom_range(0, 9) < 7), $urandom());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
